// File: rtl/event_encoder.sv
// event_encoder
//
// Converts one greyscale frame of p_s pixels into a time-ordered stream of
// one-hot events using intensity-to-latency coding. The brightest pixel fires
// first, and ties go to the lowest pixel index. Pixels below p_min_int never
// fire. Events are separated by p_gap idle cycles. o_eof pulses once no
// candidate pixel is left.
//
// Optional feature:
//   EVT_ENC_COUNT_EN  adds o_event_count, the number of events emitted in the
//                     current frame. It is cleared on frame acceptance.
//
// Ports:
//   i_clk          clock
//   i_rst_n        asynchronous reset, active low
//   i_frame        pixel k (1..p_s) at bits [k*p_pix-1 -: p_pix]
//   i_frame_valid  a frame is present on i_frame
//   o_frame_ready  a frame can be accepted (high only in IDLE)
//   o_event        one-hot event; bit k-1 is pixel k; high for one cycle
//   o_busy         a frame is being encoded
//   o_eof          one-cycle pulse when the frame is exhausted
//   o_event_count  events emitted in the current frame (EVT_ENC_COUNT_EN only)
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a frame; ready high
// EMIT  | choose the brightest unfired candidate, fire it or end the frame
// GAP   | count p_gap idle cycles before the next EMIT
`timescale 1ns/1ps

module event_encoder #(
    parameter int p_s       = 25,
    parameter int p_pix     = 8,
    parameter int p_min_int = 'h10,
    parameter int p_gap     = 'h3f,
    parameter int p_gap_w   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [p_s*p_pix-1:0] i_frame,
    input  logic                 i_frame_valid,
    output logic                 o_frame_ready,
    output logic [p_s-1:0]       o_event,
    output logic                 o_busy,
    output logic                 o_eof
`ifdef EVT_ENC_COUNT_EN
    ,
    output logic [4:0]           o_event_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [p_pix-1:0]   min_int_c = p_pix'(p_min_int);
    localparam logic [p_gap_w-1:0] gap_c     = p_gap_w'(p_gap);

    state_t               state_q, state_d;
    logic [p_pix-1:0]     pix_q [p_s];
    logic [p_s-1:0]       mask_q, mask_d;
    logic [p_gap_w-1:0]   gap_q, gap_d;
    logic [p_s-1:0]       event_q, event_d;
    logic                 eof_q, eof_d;
    logic                 capture;

    logic                 win_found;
    logic [p_pix-1:0]     win_val;
    logic [p_s-1:0]       win_oh;

    // Strict '>' on the scan keeps the earliest index on equal intensities.
    always_comb begin
        win_found = 1'b0;
        win_val   = '0;
        win_oh    = '0;
        for (int k = 0; k < p_s; k++) begin
            if (!mask_q[k] && (pix_q[k] >= min_int_c) &&
                (!win_found || (pix_q[k] > win_val))) begin
                win_found = 1'b1;
                win_val   = pix_q[k];
                win_oh    = '0;
                win_oh[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        gap_d   = gap_q;
        event_d = '0;
        eof_d   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_frame_valid) begin
                    capture = 1'b1;
                    mask_d  = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (win_found) begin
                    event_d = win_oh;
                    mask_d  = mask_q | win_oh;
                    if (p_gap == 0) begin
                        state_d = S_EMIT;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = gap_c;
                    end
                end else begin
                    eof_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                gap_d = gap_q - p_gap_w'(1);
                if (gap_q == p_gap_w'(1)) begin
                    state_d = S_EMIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            gap_q   <= '0;
            event_q <= '0;
            eof_q   <= 1'b0;
            for (int k = 0; k < p_s; k++) begin
                pix_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            gap_q   <= gap_d;
            event_q <= event_d;
            eof_q   <= eof_d;
            if (capture) begin
                for (int k = 0; k < p_s; k++) begin
                    pix_q[k] <= i_frame[k*p_pix +: p_pix];
                end
            end
        end
    end

    assign o_event       = event_q;
    assign o_eof         = eof_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_frame_ready = (state_q == S_IDLE);

`ifdef EVT_ENC_COUNT_EN
    logic [4:0] count_q;

    // Counts on the same edge that registers the event, so the count
    // matches o_event in the cycle the event is visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (capture) begin
            count_q <= '0;
        end else if (|event_d) begin
            count_q <= count_q + 5'd1;
        end
    end

    assign o_event_count = count_q;
`endif

endmodule
